// File: rtl/pp_vector_reader.sv
// Streaming row reader: walks a row range of a wide vector memory and
// hands the rows downstream through a 2-entry valid/ready buffer.
module pp_vector_reader #(
    parameter int element_width          = 64,
    parameter int memories_address_width = 20,
    parameter int no_of_units            = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [memories_address_width-1:0]      base_address,
    input  logic [memories_address_width-1:0]      row_count,
    output logic [memories_address_width-1:0]      read_address,
    input  logic [no_of_units*element_width-1:0]   memory_data,
    output logic [no_of_units*element_width-1:0]   out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy,
    output logic                                   finish
);

    localparam int AW = memories_address_width;
    localparam int DW = no_of_units * element_width;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   read_address_q;
    logic [AW-1:0]   remaining_q;
    logic [DW-1:0]   fifo_q [2];
    logic            head_q;
    logic            tail_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            finish_q;
    logic            busy_q;
    logic            pop;
    logic            push;

    assign pop  = (count_q != 2'd0) && out_ready;
    // A full buffer may still take a row when the head leaves this cycle.
    assign push = (state_q == RUN) && ((count_q != 2'd2) || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            read_address_q <= '0;
            remaining_q    <= '0;
            fifo_q[0]      <= '0;
            fifo_q[1]      <= '0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            count_q        <= 2'd0;
            finish_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            count_q  <= count_d;

            if (push) begin
                fifo_q[tail_q] <= memory_data;
                tail_q         <= ~tail_q;
                read_address_q <= read_address_q + AW'(1);
                remaining_q    <= remaining_q - AW'(1);
            end

            if (pop) begin
                head_q <= ~head_q;
            end

            unique case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        read_address_q <= base_address;
                        remaining_q    <= row_count;
                        state_q <= (row_count != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (push && (remaining_q == AW'(1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_d == 2'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // busy stays up through the finish pulse
                    finish_q <= 1'b1;
                    busy_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_address = read_address_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_data     = fifo_q[head_q];
    assign busy         = busy_q;
    assign finish       = finish_q;

endmodule

// File: tb/tb_pp_vector_reader.sv
// Randomized scoreboard bench for pp_vector_reader: expected rows are
// queued per command and popped by an independent handshake monitor.
module tb_pp_vector_reader;

    localparam int EW = 16;
    localparam int NU = 4;
    localparam int AW = 6;
    localparam int DW = EW * NU;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_address;
    logic [AW-1:0] row_count;
    logic [AW-1:0] read_address;
    logic [DW-1:0] memory_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          finish;

    logic [DW-1:0] mem [DEPTH];

    pp_vector_reader #(
        .element_width(EW),
        .memories_address_width(AW),
        .no_of_units(NU)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .base_address(base_address),
        .row_count(row_count),
        .read_address(read_address),
        .memory_data(memory_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .finish(finish)
    );

    assign memory_data = mem[read_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q [$];
    int            fin_total = 0;
    int            fin_exp = 0;
    int            popped = 0;
    bit            mon_en = 0;
    bit            track = 0;
    bit            held = 0;
    logic [DW-1:0] held_data;
    logic [AW-1:0] cmd_base = '0;
    int            ready_mode = 0;
    logic [5:0]    pat = 6'b101001;
    int            pi = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = pat[pi];
                    pi = (pi + 1) % 6;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (track) begin
                int adv;
                adv = int'(AW'(read_address - cmd_base));
                check("buffered_le_2", (adv - popped) <= 2, 1);
            end
            if (out_valid) begin
                if (held) check("stall_stable", out_data, held_data);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_row act=%h exp=none", out_data);
                    end else begin
                        check("row", out_data, exp_q.pop_front());
                    end
                    popped++;
                end
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            if (finish) fin_total++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_addr"}, read_address, 0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input int n,
                           input int mode, input bit spur);
        int e;
        bit got;
        ready_mode = mode;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_address = b;
        row_count = AW'(n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[AW'(int'(b) + i)]);
        fin_exp++;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_address = AW'($urandom);
        row_count = AW'($urandom);
        @(negedge clk);
        #1;
        check("addr_after_E0", read_address, b);
        check("busy_after_E0", busy, 1);
        cmd_base = b;
        popped = 0;
        track = 1;
        e = 0;
        got = 0;
        while (!got && e < 500) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            #1;
            if (e == 1) check("valid_after_E1", out_valid, n != 0);
            if (spur && e == 2) begin
                start = 1'b1;
                base_address = AW'(50);
                row_count = AW'(3);
            end else begin
                start = 1'b0;
            end
            if (finish) got = 1;
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL finish_timeout act=none exp=pulse base=%0d n=%0d", b, n);
            exp_q.delete();
        end else begin
            check("queue_drained", exp_q.size(), 0);
            check("busy_with_finish", busy, 1);
            if (mode == 0) check("finish_edge", e, (n == 0) ? 1 : n + 2);
        end
        @(negedge clk);
        #1;
        check("finish_one_cycle", finish, 0);
        check("busy_after_finish", busy, 0);
        track = 0;
        check("finish_count", fin_total, fin_exp);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        base_address = '0;
        row_count = '0;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = {32'($urandom), 26'($urandom), AW'(i)};
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1;

        run_cmd(AW'(10), 4, 0, 0);
        run_cmd(AW'(0), 6, 2, 0);
        run_cmd(AW'(0), 0, 0, 0);
        run_cmd(AW'(20), 5, 0, 1);
        repeat (5) @(negedge clk);
        #1;
        check("idle_no_valid", out_valid, 0);
        check("idle_no_extra_finish", fin_total, fin_exp);

        ready_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_address = AW'(30);
        row_count = AW'(5);
        for (int i = 0; i < 5; i++) exp_q.push_back(mem[30 + i]);
        @(posedge clk);
        #1;
        start = 1'b0;
        cmd_base = AW'(30);
        popped = 0;
        track = 1;
        for (int k = 0; k < 50 && popped < 2; k++) begin
            @(negedge clk);
            #1;
        end
        check("two_rows_before_reset", popped, 2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        mon_en = 0;
        track = 0;
        held = 0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1;
        repeat (3) @(negedge clk);
        #1;
        check("no_finish_after_reset", fin_total, fin_exp);

        run_cmd(AW'(7), 2, 0, 0);
        run_cmd(AW'(62), 4, 0, 0);

        for (int r = 0; r < 25; r++) begin
            int n;
            int m;
            bit s;
            n = int'($urandom_range(0, 9));
            m = int'($urandom_range(0, 2));
            s = 1'($urandom_range(0, 1)) && (n >= 2);
            run_cmd(AW'($urandom), n, m, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
